// File: rtl/bsg_sha256_padder_if.sv
// bsg_sha256_padder_if: message-word input stream (valid/ready) and padded-word output stream (valid/yumi).
interface bsg_sha256_padder_if #(parameter int word_width_p = 32);
  logic                    in_v;
  logic [word_width_p-1:0] in_data;
  logic                    in_last;
  logic [1:0]              in_last_bytes;
  logic                    in_ready;
  logic                    out_v;
  logic [word_width_p-1:0] out_data;
  logic                    out_last;
  logic                    out_yumi;
  modport master (output in_v, in_data, in_last, in_last_bytes, out_yumi,
                  input  in_ready, out_v, out_data, out_last);
  modport slave  (input  in_v, in_data, in_last, in_last_bytes, out_yumi,
                  output in_ready, out_v, out_data, out_last);
endinterface

// File: rtl/bsg_sha256_padder.sv
// bsg_sha256_padder: appends FIPS 180-4 padding and 64-bit bit length to a 32-bit word stream.
module bsg_sha256_padder #(
  parameter int word_width_p = 32,
  parameter int len_width_p  = 64
) (
  input logic               clk_i,
  input logic               reset_i,
  bsg_sha256_padder_if.slave ifc
);
  if (word_width_p != 32 || len_width_p != 64) begin : g_bad_width
    $error("bsg_sha256_padder supports only word_width_p=32 and len_width_p=64");
  end
  typedef enum logic [2:0] {PASS, PAD1, ZERO, LEN_HI, LEN_LO, DONE} state_e;
  state_e      state_r, state_n;
  logic [3:0]  idx_r;
  logic [63:0] len_r;
  logic [31:0] data_r, word, keep, pad;
  logic        v_r, last_r, free, load;
  logic [5:0]  nbits;
  assign free          = !v_r | ifc.out_yumi;
  assign load          = free && (state_r == PASS ? ifc.in_v : state_r != DONE);
  assign ifc.in_ready  = (state_r == PASS) && free;
  assign ifc.out_v     = v_r;
  assign ifc.out_data  = data_r;
  assign ifc.out_last  = last_r;
  // bits carried by the final word; the 0x80 marker lands right after them
  assign nbits = {1'b0, ifc.in_last_bytes, 3'b000} + 6'd8;
  assign keep  = ~(32'hffff_ffff >> nbits);
  assign pad   = 32'h8000_0000 >> nbits;
  always_comb begin
    word    = state_r == PASS   ? (ifc.in_last ? (ifc.in_data & keep) | pad : ifc.in_data) :
              state_r == PAD1   ? 32'h8000_0000 :
              state_r == LEN_HI ? len_r[63:32] :
              state_r == LEN_LO ? len_r[31:0] : 32'h0;
    state_n = state_r == LEN_LO                                   ? DONE   :
              state_r == LEN_HI                                   ? LEN_LO :
              (state_r == PASS && !ifc.in_last)                   ? PASS   :
              (state_r == PASS && ifc.in_last_bytes == 2'd3)      ? PAD1   :
              idx_r == 4'd13                                      ? LEN_HI : ZERO;
  end
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_r <= PASS;
      idx_r   <= '0;
      len_r   <= '0;
      data_r  <= '0;
      v_r     <= 1'b0;
      last_r  <= 1'b0;
    end else if (state_r == DONE) begin
      if (ifc.out_yumi && last_r) begin
        state_r <= PASS;
        idx_r   <= '0;
        len_r   <= '0;
        v_r     <= 1'b0;
        last_r  <= 1'b0;
      end
    end else if (load) begin
      data_r  <= word;
      last_r  <= state_r == LEN_LO;
      v_r     <= 1'b1;
      idx_r   <= idx_r + 4'd1;
      state_r <= state_n;
      if (state_r == PASS) len_r <= len_r + (ifc.in_last ? {58'b0, nbits} : 64'd32);
    end else if (ifc.out_yumi) begin
      v_r    <= 1'b0;
      last_r <= 1'b0;
    end
  end
endmodule
